// File: rtl/wave_seq_pkg.sv
// Shared types and wave-select helpers for the waveform sequencer.
package wave_seq_pkg;

  localparam int unsigned SEL_W = 3;
  localparam int unsigned ENA_W = 8;

  localparam logic [SEL_W-1:0] WS_TRI = 3'd4;
  localparam logic [SEL_W-1:0] WS_SAW = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_MUTE  = 2'd3
  } state_e;

  // Control byte layout as offered on cfg_control.
  typedef struct packed {
    logic [3:0]       rsvd;
    logic [SEL_W-1:0] sel;
    logic             run;
  } cfg_ctrl_t;

  function automatic logic ws_reserved(input logic [SEL_W-1:0] sel);
    return (sel == 3'd3) || (sel == 3'd6) || (sel == 3'd7);
  endfunction

  function automatic logic [ENA_W-1:0] ws_onehot(input logic [SEL_W-1:0] sel);
    return ws_reserved(sel) ? '0 : (ENA_W'(1) << sel);
  endfunction

  // Phase-wrap line belonging to the group that owns a select value.
  function automatic logic [2:0] ws_wrap_bit(input logic [SEL_W-1:0] sel);
    if (ws_reserved(sel)) return 3'b000;
    if (sel == WS_TRI)    return 3'b010;
    if (sel == WS_SAW)    return 3'b100;
    return 3'b001;
  endfunction

endpackage

// File: rtl/wave_seq_timer.sv
// DRAIN watchdog: counts cycles from start, flags expired on the TIMEOUT_CYC-th cycle.
module wave_seq_timer #(
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic clear,
  output logic expired
);

  localparam int unsigned LIMIT = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
  localparam int unsigned CNT_W = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;
  logic             exp_q, exp_d;

  always_comb begin
    cnt_d = cnt_q;
    run_d = run_q;
    exp_d = exp_q;
    if (clear) begin
      cnt_d = '0;
      run_d = 1'b0;
      exp_d = 1'b0;
    end else if (start) begin
      cnt_d = '0;
      run_d = 1'b1;
      exp_d = (LIMIT == 0);
    end else if (run_q && !exp_q) begin
      cnt_d = cnt_q + CNT_W'(1);
      exp_d = (cnt_d == CNT_W'(LIMIT));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      run_q <= 1'b0;
      exp_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
      exp_q <= exp_d;
    end
  end

  assign expired = exp_q;

endmodule

// File: rtl/wave_sequencer.sv
// Waveform sequencer: config handshake, drain-until-wrap mode switch and one-cycle mute.
// Define WAVE_SEQ_SOFTSTART_EN to ramp amplitude_o from 0 on every RUN entry.
module wave_sequencer
  import wave_seq_pkg::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned TIMEOUT_CYC = 65535,
  parameter int unsigned AMP_STEP    = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [7:0]        cfg_control,
  input  logic [DATA_W-1:0] cfg_prescaler,
  input  logic [DATA_W-1:0] cfg_amplitude,
  input  logic [DATA_W-1:0] data_trig,
  input  logic [DATA_W-1:0] data_tri,
  input  logic [DATA_W-1:0] data_saw,
  input  logic [2:0]        wrap_i,
  output logic [ENA_W-1:0]  ena_o,
  output logic [DATA_W-1:0] prescaler_o,
  output logic [DATA_W-1:0] amplitude_o,
  output logic [DATA_W-1:0] data_o,
  output logic              busy_o,
  output logic              timeout_o
);

  localparam logic [DATA_W-1:0] STEP = DATA_W'(AMP_STEP);

  cfg_ctrl_t         ctrl_c;
  state_e            state_q, state_d;
  logic              hs_c, live_c, timer_start_c, timer_clear_c, timer_expired;
  logic              shadow_run_q, shadow_run_d;
  logic [SEL_W-1:0]  shadow_sel_q, shadow_sel_d, act_sel_q, act_sel_d;
  logic [DATA_W-1:0] shadow_presc_q, shadow_presc_d, shadow_amp_q, shadow_amp_d;
  logic [DATA_W-1:0] act_presc_q, act_presc_d, act_amp_q, act_amp_d;
  logic [ENA_W-1:0]  ena_q, ena_d;
  logic [DATA_W-1:0] presc_q, presc_d, amp_q, amp_d, data_q, data_d, sample_c;
  logic              ready_q, ready_d, busy_q, busy_d, timeout_q, timeout_d;
  logic              unused_c;

  assign ctrl_c        = cfg_control;
  assign hs_c          = cfg_valid && ready_q;
  assign timer_start_c = (state_q == ST_RUN) && hs_c;
  assign timer_clear_c = (state_q == ST_DRAIN) && (state_d != ST_DRAIN);

  wave_seq_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (timer_start_c),
    .clear   (timer_clear_c),
    .expired (timer_expired)
  );

  // Next state, shadow capture and active-configuration selection.
  always_comb begin
    state_d        = state_q;
    shadow_run_d   = shadow_run_q;
    shadow_sel_d   = shadow_sel_q;
    shadow_presc_d = shadow_presc_q;
    shadow_amp_d   = shadow_amp_q;
    act_sel_d      = act_sel_q;
    act_presc_d    = act_presc_q;
    act_amp_d      = act_amp_q;
    timeout_d      = 1'b0;
    if (hs_c) begin
      shadow_run_d   = ctrl_c.run;
      shadow_sel_d   = ctrl_c.sel;
      shadow_presc_d = cfg_prescaler;
      shadow_amp_d   = cfg_amplitude;
    end
    case (state_q)
      ST_IDLE: begin
        if (hs_c && ctrl_c.run) begin
          state_d     = ST_RUN;
          act_sel_d   = ctrl_c.sel;
          act_presc_d = cfg_prescaler;
          act_amp_d   = cfg_amplitude;
        end
      end
      ST_RUN: begin
        if (hs_c) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (ws_reserved(act_sel_q) || (|(wrap_i & ws_wrap_bit(act_sel_q)))) begin
          state_d = ST_MUTE;
        end else if (timer_expired) begin
          state_d   = ST_MUTE;
          timeout_d = 1'b1;
        end
      end
      ST_MUTE: begin
        state_d     = shadow_run_q ? ST_RUN : ST_IDLE;
        act_sel_d   = shadow_sel_q;
        act_presc_d = shadow_presc_q;
        act_amp_d   = shadow_amp_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sample mux for the group the next cycle will be driving.
  always_comb begin
    sample_c = '0;
    if (act_sel_d == WS_TRI)          sample_c = data_tri;
    else if (act_sel_d == WS_SAW)     sample_c = data_saw;
    else if (!ws_reserved(act_sel_d)) sample_c = data_trig;
  end

  assign live_c  = (state_d == ST_RUN) || (state_d == ST_DRAIN);
  assign ena_d   = live_c ? ws_onehot(act_sel_d) : '0;
  assign presc_d = live_c ? act_presc_d : '0;
  assign data_d  = live_c ? sample_c : '0;
  assign ready_d = (state_d == ST_IDLE) || (state_d == ST_RUN);
  assign busy_d  = (state_d == ST_DRAIN) || (state_d == ST_MUTE);

`ifdef WAVE_SEQ_SOFTSTART_EN
  logic [DATA_W:0] amp_sum_c;

  // Ramp while running, freeze while draining, restart from zero on each RUN entry.
  always_comb begin
    amp_sum_c = {1'b0, amp_q} + {1'b0, STEP};
    amp_d     = '0;
    if (live_c && (state_q == ST_RUN)) begin
      amp_d = (amp_sum_c >= {1'b0, act_amp_q}) ? act_amp_q : amp_sum_c[DATA_W-1:0];
    end else if (live_c && (state_q == ST_DRAIN)) begin
      amp_d = amp_q;
    end
  end

  assign unused_c = ^ctrl_c.rsvd;
`else
  assign amp_d    = live_c ? act_amp_d : '0;
  assign unused_c = ^{ctrl_c.rsvd, STEP};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      shadow_run_q   <= 1'b0;
      shadow_sel_q   <= '0;
      shadow_presc_q <= '0;
      shadow_amp_q   <= '0;
      act_sel_q      <= '0;
      act_presc_q    <= '0;
      act_amp_q      <= '0;
      ena_q          <= '0;
      presc_q        <= '0;
      amp_q          <= '0;
      data_q         <= '0;
      ready_q        <= 1'b0;
      busy_q         <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      shadow_run_q   <= shadow_run_d;
      shadow_sel_q   <= shadow_sel_d;
      shadow_presc_q <= shadow_presc_d;
      shadow_amp_q   <= shadow_amp_d;
      act_sel_q      <= act_sel_d;
      act_presc_q    <= act_presc_d;
      act_amp_q      <= act_amp_d;
      ena_q          <= ena_d;
      presc_q        <= presc_d;
      amp_q          <= amp_d;
      data_q         <= data_d;
      ready_q        <= ready_d;
      busy_q         <= busy_d;
      timeout_q      <= timeout_d;
    end
  end

  assign cfg_ready   = ready_q;
  assign ena_o       = ena_q;
  assign prescaler_o = presc_q;
  assign amplitude_o = amp_q;
  assign data_o      = data_q;
  assign busy_o      = busy_q;
  assign timeout_o   = timeout_q;

endmodule
